// File: rtl/gf2mz_pkg.sv
// Shared types and size helpers for the GF(2^m)[z] polynomial multiplier engine.
package gf2mz_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    LD,
    MUL,
    ACC,
    WB_RD,
    WB_WAIT,
    WB,
    FIN
  } state_t;

  function automatic int calc_depth(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int calc_aw(input int depth);
    return $clog2(2 * depth);
  endfunction

endpackage

// File: rtl/gf2mz_mac_array.sv
// d x d grid of GF(2^m) multipliers folded into low/high lane vectors of one word-pair product.
// Also holds gf2m_mul, the fixed-latency field multiplier used by the grid.
module gf2m_mul #(
  parameter int m     = 67,
  parameter int K3    = 5,
  parameter int K2    = 2,
  parameter int K1    = 1,
  parameter int DELAY = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  output logic [m-1:0] prod,
  output logic         done
);
  localparam int CW = $clog2(DELAY + 1);
  localparam logic [m-1:0] POLY_LOW = (m'(1) << K3) | (m'(1) << K2) | (m'(1) << K1) | m'(1);

  logic [m-1:0]  prod_c;
  logic [CW-1:0] cnt;

  // Horner evaluation over b, reducing by the pentanomial after each shift.
  always_comb begin
    prod_c = '0;
    for (int k = m - 1; k >= 0; k--) begin
      prod_c = prod_c[m-1] ? ({prod_c[m-2:0], 1'b0} ^ POLY_LOW) : {prod_c[m-2:0], 1'b0};
      if (b[k]) prod_c = prod_c ^ a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      prod <= '0;
    end else if (start) begin
      cnt  <= CW'(DELAY);
      prod <= prod_c;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Pulses exactly DELAY cycles after the start cycle.
  assign done = (cnt == CW'(1));

endmodule

module gf2mz_mac_array #(
  parameter int m     = 67,
  parameter int d     = 5,
  parameter int K3    = 5,
  parameter int K2    = 2,
  parameter int K1    = 1,
  parameter int DELAY = 6,
  localparam int WIDTH = m * d
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             done
);
  logic [m-1:0]   lane_prod [d][d];
  logic [d*d-1:0] done_bits;

  for (genvar p = 0; p < d; p++) begin : g_row
    for (genvar q = 0; q < d; q++) begin : g_col
      gf2m_mul #(.m(m), .K3(K3), .K2(K2), .K1(K1), .DELAY(DELAY)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a[p*m +: m]),
        .b    (b[q*m +: m]),
        .prod (lane_prod[p][q]),
        .done (done_bits[p*d+q])
      );
    end
  end

  assign done = &done_bits;

  // Lane p+q lands in the low word, overflow past d-1 wraps into the high word.
  always_comb begin
    lo = '0;
    hi = '0;
    for (int p = 0; p < d; p++) begin
      for (int q = 0; q < d; q++) begin
        if (p + q < d) lo[(p+q)*m +: m] = lo[(p+q)*m +: m] ^ lane_prod[p][q];
        else           hi[(p+q-d)*m +: m] = hi[(p+q-d)*m +: m] ^ lane_prod[p][q];
      end
    end
  end

endmodule

// File: rtl/gf2mz_mul_engine.sv
// Diagonal-ordered GF(2^m)[z] polynomial multiplier over packed coefficient memories.
// Define GF2MZ_MAC_EN to enable multiply-accumulate into C (selected by acc at start).
module gf2mz_mul_engine
  import gf2mz_pkg::*;
#(
  parameter int n     = 83,
  parameter int m     = 67,
  parameter int d     = 5,
  parameter int K3    = 5,
  parameter int K2    = 2,
  parameter int K1    = 1,
  parameter int DELAY = 6,
  localparam int WIDTH = m * d,
  localparam int DEPTH = calc_depth(n, d),
  localparam int AW    = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    A_addr,
  input  logic [WIDTH-1:0] A_di,
  output logic [AW-1:0]    B_addr,
  input  logic [WIDTH-1:0] B_di,
  output logic [AW-1:0]    C_addr,
  output logic             C_we,
  output logic [WIDTH-1:0] C_do,
  input  logic [WIDTH-1:0] C_di,
  output state_t           dbg_state
);
  localparam int LAST_LANES = n - (DEPTH - 1) * d;
  localparam logic [AW-1:0] LAST_S = AW'(2 * DEPTH - 1);
  localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);

  state_t           state, state_nxt, wb_first;
  logic [AW-1:0]    s, i, j, s_nxt, i_hi;
  logic [WIDTH-1:0] lo_acc, hi_acc, carry, c_old, lo, hi, last_mask, a_m, b_m;
  logic             mac_mode, all_done, mul_start;

  function automatic logic [AW-1:0] diag_lo(input logic [AW-1:0] sv);
    return (sv > LAST_W) ? sv - LAST_W : '0;
  endfunction

  assign j     = s - i;
  assign s_nxt = s + AW'(1);
  assign i_hi  = (s < LAST_W) ? s : LAST_W;

  always_comb begin
    last_mask = '0;
    for (int k = 0; k < d; k++) last_mask[k*m +: m] = (k < LAST_LANES) ? {m{1'b1}} : '0;
  end

  // Padding lanes of the last word never reach the multipliers.
  assign a_m = (i == LAST_W) ? (A_di & last_mask) : A_di;
  assign b_m = (j == LAST_W) ? (B_di & last_mask) : B_di;

  gf2mz_mac_array #(.m(m), .d(d), .K3(K3), .K2(K2), .K1(K1), .DELAY(DELAY)) u_array (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .a    (a_m),
    .b    (b_m),
    .lo   (lo),
    .hi   (hi),
    .done (all_done)
  );

`ifdef GF2MZ_MAC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_mode <= 1'b0;
      c_old    <= '0;
    end else if (state == IDLE && start) begin
      mac_mode <= acc;
      c_old    <= '0;
    end else if (state == WB_WAIT) begin
      c_old <= C_di;
    end else if (state == WB) begin
      c_old <= '0;
    end
  end
`else
  logic unused_mac;
  assign mac_mode   = 1'b0;
  assign c_old      = '0;
  assign unused_mac = acc ^ (^C_di);
`endif

  assign wb_first = mac_mode ? WB_RD : WB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD;
      RD:      state_nxt = LD;
      LD:      state_nxt = MUL;
      MUL:     if (all_done) state_nxt = ACC;
      ACC:     state_nxt = (i == i_hi) ? wb_first : RD;
      WB_RD:   state_nxt = WB_WAIT;
      WB_WAIT: state_nxt = WB;
      // The word after the last diagonal holds only the carry.
      WB: begin
        if (s == LAST_S)           state_nxt = FIN;
        else if (s_nxt == LAST_S)  state_nxt = wb_first;
        else                       state_nxt = RD;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s      <= '0;
      i      <= '0;
      lo_acc <= '0;
      hi_acc <= '0;
      carry  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          s      <= '0;
          i      <= '0;
          lo_acc <= '0;
          hi_acc <= '0;
          carry  <= '0;
        end
        ACC: begin
          lo_acc <= lo_acc ^ lo;
          hi_acc <= hi_acc ^ hi;
          if (i != i_hi) i <= i + AW'(1);
        end
        WB: begin
          carry  <= hi_acc;
          lo_acc <= '0;
          hi_acc <= '0;
          if (s != LAST_S) begin
            s <= s_nxt;
            i <= diag_lo(s_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign mul_start = (state == LD);
  assign C_we      = (state == WB);
  assign A_addr    = i;
  assign B_addr    = j;
  assign C_addr    = s;
  assign C_do      = C_we ? (lo_acc ^ carry ^ c_old) : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_gf2mz_mul_engine.sv
// Bench for gf2mz_mul_engine with n=7, d=2 (DEPTH 4) and the default field m=67.
module tb_gf2mz_mul_engine;
  import gf2mz_pkg::*;

  localparam int N     = 7;
  localparam int M     = 67;
  localparam int D     = 2;
  localparam int DLY   = 6;
  localparam int K3    = 5;
  localparam int K2    = 2;
  localparam int K1    = 1;
  localparam int DEPTH = (N + D - 1) / D;
  localparam int W     = M * D;
  localparam int AW    = $clog2(2 * DEPTH);
  localparam int CWN   = 2 * DEPTH;
  localparam int TW    = 2 * M - 1;
  localparam int BASE_LAT = DEPTH * DEPTH * (DLY + 3) + 2 * DEPTH + 1;
`ifdef GF2MZ_MAC_EN
  localparam bit MAC_EN = 1'b1;
`else
  localparam bit MAC_EN = 1'b0;
`endif

  logic          clk, rst, start, acc, busy, done, C_we;
  logic [AW-1:0] A_addr, B_addr, C_addr;
  logic [W-1:0]  A_di, B_di, C_di, C_do;
  state_t        dbg_state;

  logic [W-1:0] a_mem [CWN];
  logic [W-1:0] b_mem [CWN];
  logic [W-1:0] c_mem [CWN];
  logic [W-1:0] c_pre [CWN];
  logic         clr, load_pre;
  int           wr_n, wr_bad, done_n;

  logic [W-1:0] exp_q [$];
  int           checks, errors;

  gf2mz_mul_engine #(.n(N), .m(M), .d(D), .K3(K3), .K2(K2), .K1(K1), .DELAY(DLY)) dut (
    .clk(clk), .rst(rst), .start(start), .acc(acc), .busy(busy), .done(done),
    .A_addr(A_addr), .A_di(A_di), .B_addr(B_addr), .B_di(B_di),
    .C_addr(C_addr), .C_we(C_we), .C_do(C_do), .C_di(C_di), .dbg_state(dbg_state)
  );

  // clock / memories / write log
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    A_di <= a_mem[A_addr];
    B_di <= b_mem[B_addr];
    C_di <= c_mem[C_addr];
    if (load_pre)  c_mem <= c_pre;
    else if (C_we) c_mem[C_addr] <= C_do;
    if (clr) begin
      wr_n   <= 0;
      wr_bad <= 0;
      done_n <= 0;
    end else begin
      if (C_we) begin
        if (int'(C_addr) != wr_n) wr_bad <= wr_bad + 1;
        wr_n <= wr_n + 1;
      end
      if (done) done_n <= done_n + 1;
    end
  end

  // helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = 1'($urandom);
    return r;
  endfunction

  // Reference field multiply: schoolbook product, then fold x^M = x^K3+x^K2+x^K1+1.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < M; k++) if (y[k]) t = t ^ (TW'(x) << k);
    for (int k = TW - 1; k >= M; k--) begin
      if (t[k]) begin
        t[k]          = 1'b0;
        t[k-M]        = ~t[k-M];
        t[k-M+K1]     = ~t[k-M+K1];
        t[k-M+K2]     = ~t[k-M+K2];
        t[k-M+K3]     = ~t[k-M+K3];
      end
    end
    return t[M-1:0];
  endfunction

  // Polynomial convolution over the first N coefficients, packed into C words.
  task automatic build_expected(input bit acc_v);
    logic [M-1:0] ac [N];
    logic [M-1:0] bc [N];
    logic [M-1:0] cc [CWN*D];
    logic [W-1:0] word;
    for (int k = 0; k < N; k++) begin
      ac[k] = a_mem[k/D][(k%D)*M +: M];
      bc[k] = b_mem[k/D][(k%D)*M +: M];
    end
    for (int k = 0; k < CWN * D; k++) cc[k] = '0;
    for (int p = 0; p < N; p++)
      for (int q = 0; q < N; q++) cc[p+q] = cc[p+q] ^ gf_mul(ac[p], bc[q]);
    exp_q.delete();
    for (int w = 0; w < CWN; w++) begin
      word = '0;
      for (int l = 0; l < D; l++) word[l*M +: M] = cc[w*D+l];
      if (MAC_EN && acc_v) word = word ^ c_pre[w];
      exp_q.push_back(word);
    end
  endtask

  // driver tasks
  task automatic clear_log();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic preload(input bit rnd);
    for (int w = 0; w < CWN; w++) c_pre[w] = rnd ? rand_word() : '0;
    load_pre = 1'b1;
    tick();
    load_pre = 1'b0;
  endtask

  task automatic clear_ab();
    for (int w = 0; w < CWN; w++) begin
      a_mem[w] = '0;
      b_mem[w] = '0;
    end
  endtask

  task automatic load_random_ab();
    for (int w = 0; w < CWN; w++) begin
      a_mem[w] = rand_word();
      b_mem[w] = rand_word();
    end
  endtask

  task automatic run_op(input bit acc_v, input int extra_at, input string tag);
    int cyc, lat;
    lat = BASE_LAT + ((MAC_EN && acc_v) ? 4 * DEPTH : 0);
    build_expected(acc_v);
    clear_log();
    start = 1'b1;
    acc   = acc_v;
    tick();
    cyc   = 1;
    start = 1'b0;
    acc   = 1'b0;
    check($sformatf("%s_busy", tag), W'(busy), W'(1));
    while (done !== 1'b1 && cyc < lat + 40) begin
      start = (cyc == extra_at);
      tick();
      cyc++;
    end
    start = 1'b0;
    check($sformatf("%s_latency", tag), W'(cyc), W'(lat));
    repeat (3) tick();
    check($sformatf("%s_idle", tag), W'(busy), '0);
    check($sformatf("%s_writes", tag), W'(wr_n), W'(CWN));
    check($sformatf("%s_order", tag), W'(wr_bad), '0);
    check($sformatf("%s_dones", tag), W'(done_n), W'(1));
    for (int k = 0; k < CWN; k++)
      check($sformatf("%s_c[%0d]", tag, k), c_mem[k], exp_q.pop_front());
  endtask

  // directed sequence
  initial begin
    int guard;
    logic [W-1:0] rw;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; acc = 1'b0; clr = 1'b0; load_pre = 1'b0;
    clear_ab();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_we", W'(C_we), '0);
    check("rst_a_addr", W'(A_addr), '0);
    check("rst_b_addr", W'(B_addr), '0);
    check("rst_c_addr", W'(C_addr), '0);
    check("rst_c_do", C_do, '0);

    // A = 1, B random (padding lane of B holds garbage)
    clear_ab();
    a_mem[0][0 +: M] = M'(1);
    for (int w = 0; w < CWN; w++) b_mem[w] = rand_word();
    preload(1'b0);
    run_op(1'b0, 0, "a_one");
    for (int k = 0; k < CWN * D; k++)
      check($sformatf("a_one_coef[%0d]", k), W'(c_mem[k/D][(k%D)*M +: M]),
            (k < N) ? W'(b_mem[k/D][(k%D)*M +: M]) : '0);

    // A = B = z^6
    clear_ab();
    a_mem[3][0 +: M] = M'(1);
    b_mem[3][0 +: M] = M'(1);
    preload(1'b1);
    run_op(1'b0, 0, "z6");
    check("z6_word6", c_mem[6], W'(1));

    // all-ones coefficients plus garbage in the padding lanes
    clear_ab();
    for (int k = 0; k < N; k++) begin
      a_mem[k/D][(k%D)*M +: M] = M'(1);
      b_mem[k/D][(k%D)*M +: M] = M'(1);
    end
    for (int l = N - (DEPTH - 1) * D; l < D; l++) begin
      rw = rand_word();
      a_mem[DEPTH-1][l*M +: M] = rw[M-1:0] | M'(1);
      rw = rand_word();
      b_mem[DEPTH-1][l*M +: M] = rw[M-1:0] | M'(1);
    end
    preload(1'b0);
    run_op(1'b0, 0, "ones_pad");

    // accumulate select, then plain overwrite over the same preload style
    load_random_ab();
    preload(1'b1);
    run_op(1'b1, 0, "mac_acc1");
    load_random_ab();
    preload(1'b1);
    run_op(1'b0, 0, "mac_acc0");

    // reset in the middle of diagonal 5, then a fresh run
    load_random_ab();
    preload(1'b0);
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (wr_n < 5 && guard < 2000) begin
      tick();
      guard++;
    end
    check("reach_diag5", W'(wr_n >= 5), W'(1));
    repeat (4) tick();
    check("busy_before_rst", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("busy_in_rst", W'(busy), '0);
    check("we_in_rst", W'(C_we), '0);
    tick();
    rst = 1'b0;
    tick();
    load_random_ab();
    preload(1'b1);
    run_op(1'b0, 0, "after_rst");

    // a second start while busy is ignored
    load_random_ab();
    preload(1'b0);
    run_op(1'b0, 20, "start_busy");

    // random operands, random preload and accumulate select
    for (int r = 0; r < 100; r++) begin
      load_random_ab();
      preload(1'b1);
      run_op(1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
